// File: rtl/ac_mq_unit.sv
// Accumulator / multiplier-quotient datapath: single-cycle load, add, subtract and
// shifts on AC, plus an unsigned shift-and-add multiply into {AC,MQ}.
module ac_mq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] mem_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ac_data,
  output logic [WIDTH-1:0] mq_data,
  output logic             zero,
  output logic             neg,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LDMQ = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_LSH  = 3'b110;
  localparam logic [2:0] OP_RSH  = 3'b111;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;

  always_comb begin
    addend  = mq_q[0] ? mcand_q : '0;
    mul_sum = {1'b0, ac_q} + {1'b0, addend};
    add_res = {1'b0, ac_q} + {1'b0, mem_data};
    sub_res = {1'b0, ac_q} - {1'b0, mem_data};

    state_d = state_q;
    ac_d    = ac_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_LOAD: begin
              ac_d    = mem_data;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_ADD: begin
              {carry_d, ac_d} = add_res;
              done_d          = 1'b1;
            end
            OP_SUB: begin
              // MSB of the widened difference is the borrow out
              {carry_d, ac_d} = sub_res;
              done_d          = 1'b1;
            end
            OP_LDMQ: begin
              mq_d   = mem_data;
              done_d = 1'b1;
            end
            OP_MUL: begin
              mcand_d = mem_data;
              ac_d    = '0;
              cnt_d   = CW'(WIDTH);
              carry_d = 1'b0;
              busy_d  = 1'b1;
              state_d = ST_MUL;
            end
            OP_LSH: begin
              ac_d    = {ac_q[WIDTH-2:0], 1'b0};
              carry_d = ac_q[WIDTH-1];
              done_d  = 1'b1;
            end
            OP_RSH: begin
              ac_d    = {1'b0, ac_q[WIDTH-1:1]};
              carry_d = ac_q[0];
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        // Add-then-shift of {c,AC,MQ}; the add carry lands in AC's MSB
        ac_d  = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ac_q    <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ac_data = ac_q;
  assign mq_data = mq_q;
  assign carry   = carry_q;
  assign zero    = (ac_q == '0);
  assign neg     = ac_q[WIDTH-1];

endmodule
